// File: rtl/head_fifo_reader_pkg.sv
// Shared definitions for the head FIFO reader: FSM encoding, default widths and
// the post-burst settle time.
package head_fifo_reader_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int BURST_LEN_DEF = 16;
  // Cycles spent in GAP so the registered fill count catches up with the burst's reads
  localparam int GAP_CYCLES    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    GAP   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/head_fifo_reader_if.sv
// Head FIFO read port plus downstream valid/ready stream of the head FIFO reader.
interface head_fifo_reader_if
  import head_fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [7:0]        fifo_num;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              burst_done;

  modport master (
    input  fifo_num, fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last, busy, burst_done
  );

  modport slave (
    output fifo_num, fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last, busy, burst_done
  );

endinterface

// File: rtl/head_fifo_reader_skid_buf.sv
// Two-entry in-order output buffer; the head entry drives the downstream stream.
module head_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic [1:0]   occ
);

  logic [W-1:0] data0;
  logic [W-1:0] data1;
  logic         v0;
  logic         v1;
  logic         do_pop;

  assign do_pop     = pop & v0;
  assign head_data  = data0;
  assign head_valid = v0;
  assign occ        = {1'b0, v0} + {1'b0, v1};

  // The reader never pushes into a full buffer unless the head pops the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data0 <= '0;
      data1 <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
    end else begin
      case ({push, do_pop})
        2'b01: begin
          data0 <= data1;
          v0    <= v1;
          v1    <= 1'b0;
        end
        2'b10: begin
          if (!v0) begin
            data0 <= push_data;
            v0    <= 1'b1;
          end else begin
            data1 <= push_data;
            v1    <= 1'b1;
          end
        end
        2'b11: begin
          if (v1) begin
            data0 <= data1;
            data1 <= push_data;
          end else begin
            data0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/head_fifo_reader.sv
// Reads fixed-length bursts from the head FIFO once enough words are queued and
// streams them downstream through a two-entry buffer, tagging the final word.
module head_fifo_reader
  import head_fifo_reader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  head_fifo_reader_if.master bus
);

  localparam logic [7:0] BURST_LEN_U8 = 8'(BURST_LEN);
  localparam logic [7:0] LAST_IDX     = 8'(BURST_LEN - 1);
  localparam logic [1:0] GAP_LAST     = 2'(GAP_CYCLES - 1);

  rd_state_e         state;
  logic [7:0]        fifo_num_reg;
  logic [7:0]        issued;
  logic [1:0]        gap_cnt;
  logic              inflight;
  logic              inflight_last;
  logic              rd_en;
  logic              xfer;
  logic              head_valid;
  logic              head_last;
  logic [1:0]        occ;
  logic [2:0]        slots_used;
  logic [DATA_W:0]   head_entry;

  assign head_last = head_entry[DATA_W];
  assign xfer      = head_valid & bus.out_ready;

  // Occupancy is counted after this cycle's transfer so a steady stream keeps one read per cycle
  assign slots_used = {1'b0, occ} - {2'b00, xfer} + {2'b00, inflight};

  always_comb begin
    rd_en = 1'b0;
    if (state == READ && issued < BURST_LEN_U8 && !bus.fifo_empty)
      rd_en = (slots_used < 3'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      fifo_num_reg  <= '0;
      issued        <= '0;
      gap_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      fifo_num_reg  <= bus.fifo_num;
      inflight      <= rd_en;
      inflight_last <= rd_en && (issued == LAST_IDX);
      case (state)
        IDLE: begin
          if (fifo_num_reg >= BURST_LEN_U8 && !bus.fifo_empty) begin
            state  <= READ;
            issued <= '0;
          end
        end
        READ: begin
          if (rd_en) begin
            issued <= issued + 8'd1;
            if (issued == LAST_IDX)
              state <= FLUSH;
          end
        end
        FLUSH: begin
          if (xfer && head_last) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 2'd1;
          if (gap_cnt == GAP_LAST)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  head_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (inflight),
    .push_data  ({inflight_last, bus.fifo_dout}),
    .pop        (xfer),
    .head_data  (head_entry),
    .head_valid (head_valid),
    .occ        (occ)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_data   = head_entry[DATA_W-1:0];
  assign bus.out_valid  = head_valid;
  assign bus.out_last   = head_valid & head_last;
  assign bus.busy       = (state != IDLE);
  assign bus.burst_done = xfer & head_last & (state == FLUSH);

endmodule

// File: tb/tb_head_fifo_reader.sv
// Bench for head_fifo_reader: a queue-backed FIFO model feeds the DUT and a
// scoreboard of expected {last, data} words is checked at each downstream transfer.
module tb_head_fifo_reader;
  import head_fifo_reader_pkg::*;

  localparam int DW = 32;
  localparam int BL = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  head_fifo_reader_if #(.DATA_W(DW)) bus ();

  head_fifo_reader #(
    .DATA_W    (DW),
    .BURST_LEN (BL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] fq[$];
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] next_word = 32'hA500_0000;
  bit            force_empty;
  int            rd_idx;
  int            cyc;
  int            checks;
  int            errors;
  logic          s_rd, s_empty, s_valid, s_ready, s_last, s_busy, s_done;
  logic [DW-1:0] s_data;

  task automatic drive_fifo_flags();
    bus.fifo_num   = (fq.size() > 255) ? 8'd255 : 8'(fq.size());
    bus.fifo_empty = (fq.size() == 0) || force_empty;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_word);
      next_word = next_word + 32'h0000_0101;
    end
    drive_fifo_flags();
  endtask

  // Sample on the falling edge, then model the FIFO returning data one cycle after rd_en
  task automatic cycle();
    @(negedge clk);
    s_rd    = bus.fifo_rd_en;
    s_empty = bus.fifo_empty;
    s_valid = bus.out_valid;
    s_ready = bus.out_ready;
    s_data  = bus.out_data;
    s_last  = bus.out_last;
    s_busy  = bus.busy;
    s_done  = bus.burst_done;
    if (s_rd === 1'b1 && fq.size() != 0) begin
      exp_q.push_back({rd_idx == BL - 1, fq[0]});
      rd_idx = (rd_idx + 1) % BL;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_rd === 1'b1 && fq.size() != 0) bus.fifo_dout = fq.pop_front();
    drive_fifo_flags();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.fifo_dout = '0;
    force_empty = 1'b0;
    fq.delete();
    exp_q.delete();
    rd_idx = 0;
    load(20);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.fifo_rd_en, bus.out_valid, bus.out_last, bus.busy, bus.burst_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rd/valid/last/busy/done=%b, want 00000",
               {bus.fifo_rd_en, bus.out_valid, bus.out_last, bus.busy, bus.burst_done});
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, want 0", bus.out_data);
    end
    checks++;
    if (dut.fifo_num_reg !== 8'd0) begin
      errors++;
      $display("FAIL reset_num_reg: got %0d, want 0", dut.fifo_num_reg);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, want IDLE", dut.state);
    end
    fq.delete();
    drive_fifo_flags();
    reset_n = 1'b1;
    repeat (3) cycle();
    checks++;
    if (s_busy !== 1'b0 || s_rd !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b rd=%b, want 0 0", s_busy, s_rd);
    end
  endtask

  task automatic test_start_threshold();
    logic c1, c2, c3;
    logic [DW:0] exp;
    int words, done_n;
    words = 0;
    done_n = 0;
    bus.out_ready = 1'b1;
    load(15);
    repeat (6) begin
      cycle();
      checks++;
      if (s_rd !== 1'b0) begin
        errors++;
        $display("FAIL thr_below: got rd_en=%b with 15 queued, want 0", s_rd);
      end
    end
    load(1);
    cycle(); c1 = s_rd;
    cycle(); c2 = s_rd;
    cycle(); c3 = s_rd;
    checks++;
    if ({c1, c2, c3} !== 3'b001) begin
      errors++;
      $display("FAIL thr_latency: got rd_en over 3 cycles=%b, want 001", {c1, c2, c3});
    end
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
        words++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL thr_word: got data=%h, want no transfer", s_data);
        end else begin
          exp = exp_q.pop_front();
          if ({s_last, s_data} !== exp) begin
            errors++;
            $display("FAIL thr_word: got last=%0b data=%h, want last=%0b data=%h",
                     s_last, s_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      if (s_done === 1'b1) done_n++;
      if (done_n > 0 && s_busy === 1'b0) break;
    end
    checks++;
    if (words != BL || done_n != 1) begin
      errors++;
      $display("FAIL thr_burst: got words=%0d dones=%0d, want %0d 1", words, done_n, BL);
    end
  endtask

  task automatic test_full_rate();
    int rd_cyc[$];
    int done_cyc[$];
    int words;
    logic [DW:0] exp;
    words = 0;
    bus.out_ready = 1'b1;
    load(40);
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (s_rd === 1'b1) rd_cyc.push_back(cyc);
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
        words++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL full_word: got data=%h, want no transfer", s_data);
        end else begin
          exp = exp_q.pop_front();
          if ({s_last, s_data} !== exp) begin
            errors++;
            $display("FAIL full_word: got last=%0b data=%h, want last=%0b data=%h",
                     s_last, s_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      if (s_done === 1'b1) begin
        done_cyc.push_back(cyc);
        checks++;
        if (words != BL * done_cyc.size() || s_last !== 1'b1) begin
          errors++;
          $display("FAIL full_done_pos: got done at word %0d last=%b, want word %0d last=1",
                   words, s_last, BL * done_cyc.size());
        end
      end
      if (done_cyc.size() == 1 && cyc > done_cyc[0] && cyc <= done_cyc[0] + 3) begin
        checks++;
        if (s_busy !== (cyc != done_cyc[0] + 3)) begin
          errors++;
          $display("FAIL full_gap_busy: got busy=%b %0d cycles after done, want %b",
                   s_busy, cyc - done_cyc[0], cyc != done_cyc[0] + 3);
        end
      end
      if (done_cyc.size() == 2 && s_busy === 1'b0) break;
    end
    checks++;
    if (rd_cyc.size() != 2 * BL || rd_cyc[BL-1] - rd_cyc[0] != BL - 1) begin
      errors++;
      $display("FAIL full_rd_run: got %0d reads, first burst span %0d, want %0d reads span %0d",
               rd_cyc.size(), (rd_cyc.size() >= BL) ? rd_cyc[BL-1] - rd_cyc[0] : -1, 2 * BL, BL - 1);
    end
    checks++;
    if (words != 2 * BL || done_cyc.size() != 2) begin
      errors++;
      $display("FAIL full_total: got words=%0d dones=%0d, want %0d 2", words, done_cyc.size(), 2 * BL);
    end
    fq.delete();
    drive_fifo_flags();
    repeat (2) cycle();
  endtask

  task automatic test_backpressure();
    int words, lasts, done_n, rd_tot, x_tot;
    logic pv, pr;
    logic [DW-1:0] pd;
    logic [DW:0] exp;
    words = 0; lasts = 0; done_n = 0; rd_tot = 0; x_tot = 0;
    pv = 1'b0; pr = 1'b1; pd = '0;
    load(16);
    for (int k = 0; k < 400; k++) begin
      bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      cycle();
      if (s_rd === 1'b1) rd_tot++;
      if (pv === 1'b1 && pr === 1'b0) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== pd) begin
          errors++;
          $display("FAIL bp_hold: got valid=%b data=%h, want valid=1 data=%h", s_valid, s_data, pd);
        end
      end
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
        words++;
        x_tot++;
        if (s_last === 1'b1) lasts++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_word: got data=%h, want no transfer", s_data);
        end else begin
          exp = exp_q.pop_front();
          if ({s_last, s_data} !== exp) begin
            errors++;
            $display("FAIL bp_word: got last=%0b data=%h, want last=%0b data=%h",
                     s_last, s_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      checks++;
      if (rd_tot - x_tot > 2) begin
        errors++;
        $display("FAIL bp_outstanding: got %0d words outstanding, want at most 2", rd_tot - x_tot);
      end
      pv = s_valid; pr = s_ready; pd = s_data;
      if (s_done === 1'b1) done_n++;
      if (done_n > 0 && s_busy === 1'b0) break;
    end
    checks++;
    if (words != BL || lasts != 1 || done_n != 1) begin
      errors++;
      $display("FAIL bp_total: got words=%0d lasts=%0d dones=%0d, want %0d 1 1", words, lasts, done_n, BL);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_empty_mid_burst();
    int words, lasts, done_n, empty_left;
    bit trig;
    logic [DW:0] exp;
    words = 0; lasts = 0; done_n = 0; empty_left = 0; trig = 1'b0;
    bus.out_ready = 1'b1;
    load(16);
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (empty_left > 0) begin
        checks++;
        if (s_rd !== 1'b0 || s_empty !== 1'b1) begin
          errors++;
          $display("FAIL empty_pause: got rd_en=%b empty=%b, want 0 1", s_rd, s_empty);
        end
        empty_left--;
        if (empty_left == 0) begin
          force_empty = 1'b0;
          drive_fifo_flags();
        end
      end
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
        words++;
        if (s_last === 1'b1) lasts++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL empty_word: got data=%h, want no transfer", s_data);
        end else begin
          exp = exp_q.pop_front();
          if ({s_last, s_data} !== exp) begin
            errors++;
            $display("FAIL empty_word: got last=%0b data=%h, want last=%0b data=%h",
                     s_last, s_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      if (!trig && words == 7) begin
        trig = 1'b1;
        force_empty = 1'b1;
        drive_fifo_flags();
        empty_left = 5;
      end
      if (s_done === 1'b1) done_n++;
      if (done_n > 0 && s_busy === 1'b0) break;
    end
    checks++;
    if (words != BL || lasts != 1 || done_n != 1) begin
      errors++;
      $display("FAIL empty_total: got words=%0d lasts=%0d dones=%0d, want %0d 1 1", words, lasts, done_n, BL);
    end
  endtask

  task automatic test_back_to_back();
    int words, done1, rd2;
    int done_n;
    logic [DW:0] exp;
    words = 0; done1 = -1; rd2 = -1; done_n = 0;
    bus.out_ready = 1'b1;
    load(32);
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (s_rd === 1'b1 && done_n == 1 && rd2 < 0) rd2 = cyc;
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
        words++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_word: got data=%h, want no transfer", s_data);
        end else begin
          exp = exp_q.pop_front();
          if ({s_last, s_data} !== exp) begin
            errors++;
            $display("FAIL b2b_word: got last=%0b data=%h, want last=%0b data=%h",
                     s_last, s_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      if (s_done === 1'b1) begin
        done_n++;
        if (done_n == 1) done1 = cyc;
      end
      if (done_n == 2 && s_busy === 1'b0) break;
    end
    checks++;
    if (done1 < 0 || rd2 < 0 || rd2 - done1 < 4) begin
      errors++;
      $display("FAIL b2b_gap: got second burst read %0d cycles after first done, want at least 4", rd2 - done1);
    end
    checks++;
    if (words != 2 * BL || done_n != 2) begin
      errors++;
      $display("FAIL b2b_total: got words=%0d dones=%0d, want %0d 2", words, done_n, 2 * BL);
    end
    load(BL - 1);
    repeat (20) begin
      cycle();
      checks++;
      if (s_rd !== 1'b0 || s_busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_no_third: got rd_en=%b busy=%b with %0d queued, want 0 0", s_rd, s_busy, BL - 1);
      end
    end
    fq.delete();
    drive_fifo_flags();
    repeat (2) cycle();
  endtask

  task automatic test_reset_mid_burst();
    int words, lasts, done_n;
    logic [DW:0] exp;
    words = 0;
    bus.out_ready = 1'b1;
    load(20);
    for (int k = 0; k < 100 && words < 5; k++) begin
      cycle();
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
        words++;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
      end
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.fifo_rd_en, bus.out_valid, bus.out_last, bus.busy, bus.burst_done} !== 5'b0 ||
        bus.out_data !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got rd/valid/last/busy/done=%b data=%h, want 00000 0",
               {bus.fifo_rd_en, bus.out_valid, bus.out_last, bus.busy, bus.burst_done}, bus.out_data);
    end
    exp_q.delete();
    rd_idx = 0;
    fq.delete();
    load(16);
    repeat (2) cycle();
    reset_n = 1'b1;
    words = 0; lasts = 0; done_n = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
        words++;
        if (s_last === 1'b1) lasts++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL midrst_word: got data=%h, want no transfer", s_data);
        end else begin
          exp = exp_q.pop_front();
          if ({s_last, s_data} !== exp) begin
            errors++;
            $display("FAIL midrst_word: got last=%0b data=%h, want last=%0b data=%h",
                     s_last, s_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      if (s_done === 1'b1) done_n++;
      if (done_n > 0 && s_busy === 1'b0) break;
    end
    checks++;
    if (words != BL || lasts != 1 || done_n != 1) begin
      errors++;
      $display("FAIL midrst_total: got words=%0d lasts=%0d dones=%0d, want %0d 1 1", words, lasts, done_n, BL);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_start_threshold();
    test_full_rate();
    test_backpressure();
    test_empty_mid_burst();
    test_back_to_back();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
